// File: rtl/uart_mem_dump_pkg.sv
// Shared encodings and defaults for the UART memory dump block and its byte transmitter.
package uart_mem_dump_pkg;

    localparam int UART_CLKS_PER_BIT = 87;
    localparam int UART_ADR_W        = 15;
    localparam int UART_DUMP_ST_LEN  = 3;

    typedef enum logic [UART_DUMP_ST_LEN-1:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5,
        ST_DONE  = 3'd6
    } dump_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_phase_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer: a byte accepted on valid is framed start/data(LSB first)/stop on a registered tx.
// A new byte offered in the last stop-bit cycle starts its start bit with no idle gap.
module uart_tx_byte
    import uart_mem_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       bit_end,
    output logic       last_data,
    output logic       tx
);

    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CLKS_PER_BIT - 1);

    tx_phase_e        phase_q;
    tx_phase_e        phase_d;
    logic [TMR_W-1:0] tmr_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= TX_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            TX_IDLE:  if (valid) phase_d = TX_START;
            TX_START: if (bit_end) phase_d = TX_DATA;
            TX_DATA:  if (bit_end && last_data) phase_d = TX_STOP;
            TX_STOP:  if (bit_end) phase_d = valid ? TX_START : TX_IDLE;
            default:  phase_d = TX_IDLE;
        endcase
    end

    always_comb begin
        bit_end   = (phase_q != TX_IDLE) && (tmr_q == TMR_MAX);
        last_data = (phase_q == TX_DATA) && (bit_q == 3'd7);
        ready     = (phase_q == TX_STOP) && bit_end;
        load      = valid && ((phase_q == TX_IDLE) || ready);
    end

    // tx is updated on the edge that enters each bit, so the line never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else if (load) begin
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= data;
            tx_q    <= 1'b0;
        end else if (phase_q != TX_IDLE) begin
            if (bit_end) begin
                tmr_q <= '0;
                case (phase_q)
                    TX_START: tx_q <= shift_q[0];
                    TX_DATA: begin
                        if (last_data) begin
                            tx_q <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                    default: tx_q <= 1'b1;
                endcase
            end else begin
                tmr_q <= tmr_q + 1'b1;
            end
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/uart_mem_dump.sv
// Reads a range of memory words on a start pulse and streams them out little-endian over UART 8N1.
// Address bit 14 picks dmem vs imem; that decode lives on the memory side, shared with the programmer.
module uart_mem_dump
    import uart_mem_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int ADR_W        = UART_ADR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [ADR_W-1:0] start_adr_i,
    input  logic [ADR_W-1:0] word_cnt_i,
    output logic             mem_ren_o,
    output logic [ADR_W-1:0] mem_adr_o,
    input  logic [31:0]      mem_dat_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    dump_state_e      state_q;
    dump_state_e      state_d;
    logic [ADR_W-1:0] adr_q;
    logic [ADR_W-1:0] cnt_q;
    logic [31:0]      word_q;
    logic [1:0]       byte_q;

    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic             tx_bit_end;
    logic             tx_last_data;
    logic             last_byte;

    assign last_byte = (byte_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // START/DATA/STOP track the serializer's own phases, advanced by its bit-end strobes
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = (word_cnt_i == '0) ? ST_DONE : ST_READ;
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_START;
            ST_START: if (tx_bit_end) state_d = ST_DATA;
            ST_DATA:  if (tx_bit_end && tx_last_data) state_d = ST_STOP;
            ST_STOP: begin
                if (tx_ready) begin
                    if (!last_byte)                      state_d = ST_START;
                    else if (cnt_q == ADR_W'(1))         state_d = ST_DONE;
                    else                                 state_d = ST_READ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_ren_o = (state_q == ST_READ);
        mem_adr_o = adr_q;
        done_o    = (state_q == ST_DONE);
        busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
        tx_valid  = (state_q == ST_WAIT) ||
                    ((state_q == ST_STOP) && tx_ready && !last_byte);
        tx_data   = (state_q == ST_WAIT) ? mem_dat_i[7:0] : word_q[15:8];
    end

    // word_q shifts down one byte per frame so the next byte is always at [15:8]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q  <= '0;
            cnt_q  <= '0;
            word_q <= '0;
            byte_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        adr_q <= start_adr_i;
                        cnt_q <= word_cnt_i;
                    end
                end
                ST_WAIT: begin
                    word_q <= mem_dat_i;
                    byte_q <= '0;
                end
                ST_STOP: begin
                    if (tx_ready) begin
                        if (last_byte) begin
                            adr_q <= adr_q + 1'b1;
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            byte_q <= byte_q + 2'd1;
                            word_q <= word_q >> 8;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (tx_valid),
        .data      (tx_data),
        .ready     (tx_ready),
        .bit_end   (tx_bit_end),
        .last_data (tx_last_data),
        .tx        (tx_o)
    );

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench for uart_mem_dump: decodes tx frames at mid-bit and checks latency, gaps and handshakes.
module tb_uart_mem_dump;

    localparam int CPB = 87;
    localparam int AW  = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [AW-1:0] start_adr_i;
    logic [AW-1:0] word_cnt_i;
    logic          mem_ren_o;
    logic [AW-1:0] mem_adr_o;
    logic [31:0]   mem_dat_i = 32'h0BADF00D;
    logic          tx_o;
    logic          busy_o;
    logic          done_o;

    int checks   = 0;
    int failures = 0;
    int ren_cnt    = 0;
    int done_cnt   = 0;
    int tx_low_cnt = 0;
    int r0, d0, l0;

    always #5 clk = ~clk;

    uart_mem_dump #(.CLKS_PER_BIT(CPB), .ADR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .start_adr_i (start_adr_i),
        .word_cnt_i  (word_cnt_i),
        .mem_ren_o   (mem_ren_o),
        .mem_adr_o   (mem_adr_o),
        .mem_dat_i   (mem_dat_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    function automatic logic [31:0] mem_model(input logic [AW-1:0] a);
        case (a)
            15'h4000: return 32'hA55A0F31;
            15'h7FFF: return 32'h11223344;
            15'h0000: return 32'hDEADBEEF;
            default:  return {16'hC0DE, 1'b0, a};
        endcase
    endfunction

    // Synchronous read port: data valid only in the cycle after the read enable
    always @(posedge clk) begin
        if (mem_ren_o) mem_dat_i <= mem_model(mem_adr_o);
        else           mem_dat_i <= 32'h0BADF00D;
    end

    always @(posedge clk) begin
        if (mem_ren_o) ren_cnt    <= ren_cnt + 1;
        if (done_o)    done_cnt   <= done_cnt + 1;
        if (!tx_o)     tx_low_cnt <= tx_low_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] adr, input logic [AW-1:0] cnt);
        @(negedge clk);
        start_i     = 1'b1;
        start_adr_i = adr;
        word_cnt_i  = cnt;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Called right after the accepting edge; start bit must begin two edges later
    task automatic wait_start(input string tag);
        int k = 0;
        while (tx_o !== 1'b0 && k < 20) begin
            tick(1);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'd2);
    endtask

    // Called just after the edge that began the start bit; returns on the edge that ends the stop bit
    task automatic rx_frame(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        tick(1);
        start_i = 1'b0;
        tick(42);
        check({tag, "_start"}, 32'(tx_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(CPB);
            b[i] = tx_o;
        end
        check({tag, "_data"}, 32'(b), 32'(exp));
        tick(CPB);
        check({tag, "_stop"}, 32'(tx_o), 32'd1);
        tick(44);
    endtask

    task automatic rx_word(input string tag, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            rx_frame($sformatf("%s_b%0d", tag, i), w[8*i +: 8]);
            if (i < 3) check($sformatf("%s_b2b%0d", tag, i), 32'(tx_o), 32'd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        start_adr_i = '0;
        word_cnt_i  = '0;
        tick(3);
        check("rst_tx",   32'(tx_o),      32'd1);
        check("rst_busy", 32'(busy_o),    32'd0);
        check("rst_done", 32'(done_o),    32'd0);
        check("rst_ren",  32'(mem_ren_o), 32'd0);
        check("rst_adr",  32'(mem_adr_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        check("idle_tx",   32'(tx_o),   32'd1);
        check("idle_busy", 32'(busy_o), 32'd0);

        // Empty request: done one cycle after start, nothing read or sent
        r0 = ren_cnt; d0 = done_cnt; l0 = tx_low_cnt;
        pulse_start(15'h1234, 15'd0);
        check("empty_done", 32'(done_o),    32'd1);
        check("empty_busy", 32'(busy_o),    32'd0);
        check("empty_ren",  32'(mem_ren_o), 32'd0);
        tick(1);
        check("empty_done_clr", 32'(done_o), 32'd0);
        tick(20);
        check("empty_ren_cnt",  32'(ren_cnt - r0),    32'd0);
        check("empty_tx_low",   32'(tx_low_cnt - l0), 32'd0);
        check("empty_done_cnt", 32'(done_cnt - d0),   32'd1);

        // Single dmem word, little-endian byte order
        r0 = ren_cnt; d0 = done_cnt;
        pulse_start(15'h4000, 15'd1);
        check("w1_ren",  32'(mem_ren_o), 32'd1);
        check("w1_adr",  32'(mem_adr_o), 32'h4000);
        check("w1_busy", 32'(busy_o),    32'd1);
        wait_start("w1");
        rx_word("w1", 32'hA55A0F31);
        check("w1_done",      32'(done_o), 32'd1);
        check("w1_busy_done", 32'(busy_o), 32'd0);
        check("w1_tx_idle",   32'(tx_o),   32'd1);
        tick(1);
        check("w1_done_clr", 32'(done_o),         32'd0);
        check("w1_done_cnt", 32'(done_cnt - d0),  32'd1);
        check("w1_ren_cnt",  32'(ren_cnt - r0),   32'd1);

        // Address wrap 0x7FFF -> 0x0000 with a two-cycle idle gap between words
        d0 = done_cnt;
        pulse_start(15'h7FFF, 15'd2);
        check("wr_adr0", 32'(mem_adr_o), 32'h7FFF);
        wait_start("wr");
        rx_word("wr0", 32'h11223344);
        check("wr_gap0_tx",   32'(tx_o),      32'd1);
        check("wr_ren1",      32'(mem_ren_o), 32'd1);
        check("wr_adr1",      32'(mem_adr_o), 32'h0000);
        check("wr_done_mid",  32'(done_o),    32'd0);
        tick(1);
        check("wr_gap1_tx",   32'(tx_o),      32'd1);
        check("wr_gap1_ren",  32'(mem_ren_o), 32'd0);
        tick(1);
        check("wr_gap_end",   32'(tx_o),      32'd0);
        rx_word("wr1", 32'hDEADBEEF);
        check("wr_done",      32'(done_o),        32'd1);
        check("wr_done_cnt",  32'(done_cnt - d0), 32'd0);

        // Second start while busy must be ignored
        tick(2);
        r0 = ren_cnt; d0 = done_cnt;
        pulse_start(15'h0010, 15'd1);
        wait_start("bz");
        start_adr_i = 15'h0020;
        word_cnt_i  = 15'd5;
        start_i     = 1'b1;
        rx_word("bz", 32'hC0DE0010);
        check("bz_done", 32'(done_o), 32'd1);
        l0 = tx_low_cnt;
        tick(300);
        check("bz_ren_cnt",  32'(ren_cnt - r0),    32'd1);
        check("bz_done_cnt", 32'(done_cnt - d0),   32'd1);
        check("bz_tx_quiet", 32'(tx_low_cnt - l0), 32'd0);

        // Asynchronous reset in bit 3 of byte 1 abandons the frame
        pulse_start(15'h0010, 15'd1);
        wait_start("rs");
        rx_frame("rs_b0", 8'h10);
        tick(4*CPB + 20);
        check("rs_bit3", 32'(tx_o), 32'd0);
        d0 = done_cnt;
        #3 rst_n = 1'b0;
        #1;
        check("rs_tx",   32'(tx_o),      32'd1);
        check("rs_busy", 32'(busy_o),    32'd0);
        check("rs_done", 32'(done_o),    32'd0);
        check("rs_ren",  32'(mem_ren_o), 32'd0);
        check("rs_adr",  32'(mem_adr_o), 32'd0);
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        l0 = tx_low_cnt; r0 = ren_cnt;
        tick(1000);
        check("rs_no_done",   32'(done_cnt - d0),   32'd0);
        check("rs_no_resume", 32'(tx_low_cnt - l0), 32'd0);
        check("rs_no_read",   32'(ren_cnt - r0),    32'd0);
        check("rs_idle_busy", 32'(busy_o),          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
